// File: rtl/ascensor_pkg.sv
// ascensor_pkg: constants shared by the elevator controller, the display
// controller and the LED logic.
//   DIR_*   : encoding of the direccion output (11 is never driven).
//   REPOSO, MOVIENDO, PUERTAS : controller state encoding.
//   asc_max : elaboration-time helper for sizing the shared timer.
package ascensor_pkg;

  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_SUBE   = 2'b01;
  localparam logic [1:0] DIR_BAJA   = 2'b10;

  localparam logic [1:0] REPOSO     = 2'd0;
  localparam logic [1:0] MOVIENDO   = 2'd1;
  localparam logic [1:0] PUERTAS    = 2'd2;

  function automatic int asc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascensor_temporizador.sv
// ascensor_temporizador: loadable down-counter that saturates at zero.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset (count clears to 0)
//   cargar : load valor this cycle (takes priority over counting)
//   valor  : value to load
//   cero   : count is zero
module ascensor_temporizador #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cargar,
  input  logic [W-1:0] valor,
  output logic         cero
);

  logic [W-1:0] r_cuenta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cuenta <= '0;
    end else if (cargar) begin
      r_cuenta <= valor;
    end else if (r_cuenta != '0) begin
      r_cuenta <= r_cuenta - W'(1);
    end
  end

  assign cero = (r_cuenta == '0);

endmodule

// File: rtl/ascensor_ctrl.sv
// ascensor_ctrl: single-car elevator controller with collective (SCAN) service.
// Latches per-floor calls, finishes the current direction before reversing,
// and opens the doors for T_PUERTA cycles at each served floor.
// Ports:
//   clk              : system clock
//   rst_n            : synchronous active-low reset
//   llamadas         : per-floor call requests (pulse or level)
//   mantener_puerta  : hold doors open (only with ASC_MANTENER_PUERTA_EN)
//   piso             : current floor
//   direccion        : 00 stopped, 01 up, 10 down
//   puertas_abiertas : doors open
//   pendientes       : latched outstanding calls
// Optional feature macro: ASC_MANTENER_PUERTA_EN adds the mantener_puerta input.
module ascensor_ctrl
  import ascensor_pkg::*;
#(
  parameter int N_PISOS  = 4,
  parameter int T_VIAJE  = 50_000_000,
  parameter int T_PUERTA = 100_000_000,
  localparam int PISO_W  = (N_PISOS > 1) ? $clog2(N_PISOS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] llamadas,
`ifdef ASC_MANTENER_PUERTA_EN
  input  logic               mantener_puerta,
`endif
  output logic [PISO_W-1:0]  piso,
  output logic [1:0]         direccion,
  output logic               puertas_abiertas,
  output logic [N_PISOS-1:0] pendientes
);

  localparam int TW = $clog2(asc_max(T_VIAJE, T_PUERTA) + 1);
  localparam logic [TW-1:0] C_VIAJE  = TW'(T_VIAJE - 1);
  localparam logic [TW-1:0] C_PUERTA = TW'(T_PUERTA - 1);

  logic [1:0]         r_estado;
  logic [PISO_W-1:0]  r_piso;
  logic [1:0]         r_dir;
  logic               r_ult_sube;
  logic [N_PISOS-1:0] r_pend;

  logic               w_cero;
  logic               w_mantener;
  logic               w_llegada;
  logic [PISO_W-1:0]  w_piso_eval;
  logic               w_ult_sube_d;
  logic [N_PISOS-1:0] w_arriba;
  logic [N_PISOS-1:0] w_abajo;
  logic               w_aqui;
  logic               w_llamada_aqui;
  logic [1:0]         w_dec_estado;
  logic [1:0]         w_dec_dir;
  logic [1:0]         w_estado_d;
  logic [1:0]         w_dir_d;
  logic               w_cargar;
  logic [TW-1:0]      w_valor;
  logic [N_PISOS-1:0] w_clr;

`ifdef ASC_MANTENER_PUERTA_EN
  assign w_mantener = mantener_puerta;
`else
  assign w_mantener = 1'b0;
`endif

  ascensor_temporizador #(
    .W (TW)
  ) u_temporizador (
    .clk    (clk),
    .rst_n  (rst_n),
    .cargar (w_cargar),
    .valor  (w_valor),
    .cero   (w_cero)
  );

  // On arrival the decision is taken against the floor just reached, so all
  // masks are built on w_piso_eval rather than the registered floor.
  always_comb begin
    w_llegada   = (r_estado == MOVIENDO) && w_cero;
    w_piso_eval = r_piso;
    if (w_llegada) begin
      if (r_dir == DIR_SUBE) w_piso_eval = r_piso + PISO_W'(1);
      else                   w_piso_eval = r_piso - PISO_W'(1);
    end
    w_ult_sube_d = w_llegada ? (r_dir == DIR_SUBE) : r_ult_sube;
  end

  always_comb begin
    w_arriba       = '0;
    w_abajo        = '0;
    w_aqui         = 1'b0;
    w_llamada_aqui = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (i > int'(w_piso_eval))  w_arriba[i]    = r_pend[i];
      if (i < int'(w_piso_eval))  w_abajo[i]     = r_pend[i];
      if (i == int'(w_piso_eval)) w_aqui         = r_pend[i];
      if (i == int'(r_piso))      w_llamada_aqui = llamadas[i];
    end
  end

  // Decision function: serve here, else keep sweeping, else reverse.
  always_comb begin
    w_dec_estado = REPOSO;
    w_dec_dir    = DIR_PARADO;
    if (w_aqui) begin
      w_dec_estado = PUERTAS;
    end else if ((|w_arriba) && (|w_abajo)) begin
      w_dec_estado = MOVIENDO;
      w_dec_dir    = w_ult_sube_d ? DIR_SUBE : DIR_BAJA;
    end else if (|w_arriba) begin
      w_dec_estado = MOVIENDO;
      w_dec_dir    = DIR_SUBE;
    end else if (|w_abajo) begin
      w_dec_estado = MOVIENDO;
      w_dec_dir    = DIR_BAJA;
    end
  end

  always_comb begin
    w_estado_d = r_estado;
    w_dir_d    = r_dir;
    w_cargar   = 1'b0;
    w_valor    = C_PUERTA;
    case (r_estado)
      REPOSO, MOVIENDO: begin
        if (r_estado == REPOSO || w_llegada) begin
          w_estado_d = w_dec_estado;
          w_dir_d    = w_dec_dir;
          w_cargar   = (w_dec_estado != REPOSO);
          w_valor    = (w_dec_estado == MOVIENDO) ? C_VIAJE : C_PUERTA;
        end
      end
      PUERTAS: begin
        // A new call for this floor is absorbed by restarting the door time.
        if (w_llamada_aqui || w_mantener) begin
          w_cargar = 1'b1;
        end else if (w_cero) begin
          w_estado_d = REPOSO;
        end
      end
      default: begin
        w_estado_d = REPOSO;
        w_dir_d    = DIR_PARADO;
      end
    endcase
  end

  // Served floor is masked both on door entry and for the whole door phase.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (w_estado_d == PUERTAS && i == int'(w_piso_eval)) w_clr[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado   <= REPOSO;
      r_piso     <= '0;
      r_dir      <= DIR_PARADO;
      r_ult_sube <= 1'b1;
      r_pend     <= '0;
    end else begin
      r_estado   <= w_estado_d;
      r_piso     <= w_piso_eval;
      r_dir      <= w_dir_d;
      r_ult_sube <= w_ult_sube_d;
      r_pend     <= (r_pend | llamadas) & ~w_clr;
    end
  end

  assign piso             = r_piso;
  assign direccion        = r_dir;
  assign puertas_abiertas = (r_estado == PUERTAS);
  assign pendientes       = r_pend;

endmodule

// File: tb/tb_ascensor_ctrl.sv
// tb_ascensor_ctrl: self-checking bench for ascensor_ctrl (4 floors, T_VIAJE=8,
// T_PUERTA=4). A behavioural model tracks floor, remaining travel/door cycles
// and the pending set; outputs are compared against it every cycle, with
// directed scenarios pinned by literal expectations and a random phase after.
module tb_ascensor_ctrl;

  localparam int NP = 4;
  localparam int TV = 8;
  localparam int TP = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NP-1:0] llamadas = '0;
  logic          hold = 1'b0;
  logic [1:0]    piso;
  logic [1:0]    direccion;
  logic          puertas_abiertas;
  logic [NP-1:0] pendientes;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  ascensor_ctrl #(
    .N_PISOS  (NP),
    .T_VIAJE  (TV),
    .T_PUERTA (TP)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .llamadas         (llamadas),
`ifdef ASC_MANTENER_PUERTA_EN
    .mantener_puerta  (hold),
`endif
    .piso             (piso),
    .direccion        (direccion),
    .puertas_abiertas (puertas_abiertas),
    .pendientes       (pendientes)
  );

  // ---------------- behavioural model ----------------
  int          m_floor;
  int          m_dir;     // +1 up, -1 down, 0 not moving
  int          m_last;    // last travelled direction
  int          m_travel;  // edges left until next floor
  int          m_door;    // door cycles left including the current one
  bit [NP-1:0] m_pend;
  bit [NP-1:0] m_llam;
  int          m_act;

  // 0: open doors, +1/-1: move, 2: stay idle
  function automatic int decide(input int f, input int last);
    int above = 0;
    int below = 0;
    if (m_pend[f]) return 0;
    for (int i = 0; i < NP; i++) begin
      if (m_pend[i] && i > f) above++;
      if (m_pend[i] && i < f) below++;
    end
    if (above > 0 && below > 0) return last;
    if (above > 0) return 1;
    if (below > 0) return -1;
    return 2;
  endfunction

  task automatic apply(input int act);
    if (act == 0) begin
      m_dir  = 0;
      m_door = TP;
    end else if (act == 2) begin
      m_dir = 0;
    end else begin
      m_dir    = act;
      m_travel = TV;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_floor = 0; m_dir = 0; m_last = 1; m_travel = 0; m_door = 0; m_pend = '0;
    end else begin
      m_llam = llamadas;
      if (m_door > 0) begin
        if (m_llam[m_floor] || hold) m_door = TP;
        else m_door--;
      end else if (m_dir != 0) begin
        m_travel--;
        if (m_travel == 0) begin
          m_floor += m_dir;
          m_last  = m_dir;
          m_act   = decide(m_floor, m_last);
          apply(m_act);
        end
      end else begin
        m_act = decide(m_floor, m_last);
        apply(m_act);
      end
      m_pend = m_pend | m_llam;
      if (m_door > 0) m_pend[m_floor] = 1'b0;
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- checking ----------------
  function automatic void check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_piso", int'(piso), m_floor);
      check("model_dir", int'(direccion), (m_dir == 1) ? 1 : ((m_dir == -1) ? 2 : 0));
      check("model_doors", int'(puertas_abiertas), (m_door > 0) ? 1 : 0);
      check("model_pend", int'(pendientes), int'(m_pend));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    llamadas = '0;
    hold = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // 1. reset with all calls asserted
    rst_n = 1'b0;
    llamadas = 4'b1111;
    tick(3);
    chk_en = 1'b1;
    check("rst_piso", int'(piso), 0);
    check("rst_dir", int'(direccion), 0);
    check("rst_doors", int'(puertas_abiertas), 0);
    check("rst_pend", int'(pendientes), 0);
    rst_n = 1'b1;
    llamadas = '0;
    tick(2);

    // 2. call to top floor from floor 0
    llamadas = 4'b1000;
    tick(1); llamadas = '0;
    check("s2_pend", int'(pendientes), 8);
    check("s2_dir0", int'(direccion), 0);
    tick(1); check("s2_dir_up", int'(direccion), 1);
    tick(8); check("s2_piso1", int'(piso), 1);
    tick(8); check("s2_piso2", int'(piso), 2);
    tick(8); check("s2_piso3", int'(piso), 3);
    check("s2_doors", int'(puertas_abiertas), 1);
    check("s2_pend0", int'(pendientes), 0);
    check("s2_dir_stop", int'(direccion), 0);
    tick(3); check("s2_doors_last", int'(puertas_abiertas), 1);
    tick(1); check("s2_doors_closed", int'(puertas_abiertas), 0);

    // 3. call at current floor, re-pulse during door cycle 2
    do_reset();
    llamadas = 4'b0001;
    tick(1); llamadas = '0;
    check("s3_pend", int'(pendientes), 1);
    tick(1); check("s3_doors", int'(puertas_abiertas), 1);
    check("s3_dir", int'(direccion), 0);
    check("s3_pend0", int'(pendientes), 0);
    tick(1); llamadas = 4'b0001;
    tick(1); llamadas = '0;
    check("s3_absorbed", int'(pendientes), 0);
    tick(3); check("s3_doors_ext", int'(puertas_abiertas), 1);
    tick(1); check("s3_doors_closed", int'(puertas_abiertas), 0);

    // 4. intermediate call picked up on the way
    do_reset();
    llamadas = 4'b1000;
    tick(1); llamadas = '0;
    tick(1); check("s4_dir_up", int'(direccion), 1);
    tick(3); llamadas = 4'b0010;
    tick(1); llamadas = '0;
    check("s4_pend", int'(pendientes), 10);
    tick(4); check("s4_piso1", int'(piso), 1);
    check("s4_doors1", int'(puertas_abiertas), 1);
    check("s4_pend1", int'(pendientes), 8);
    tick(4); check("s4_closed", int'(puertas_abiertas), 0);
    check("s4_idle_dir", int'(direccion), 0);
    tick(1); check("s4_resume", int'(direccion), 1);
    tick(16); check("s4_piso3", int'(piso), 3);
    check("s4_doors3", int'(puertas_abiertas), 1);

    // 5. calls above and below at floor 2 after travelling up
    do_reset();
    llamadas = 4'b0100;
    tick(1); llamadas = '0;
    tick(17); check("s5_piso2", int'(piso), 2);
    check("s5_doors2", int'(puertas_abiertas), 1);
    tick(4); llamadas = 4'b1001;
    tick(1); llamadas = '0;
    check("s5_pend", int'(pendientes), 9);
    tick(1); check("s5_up_first", int'(direccion), 1);
    tick(8); check("s5_piso3", int'(piso), 3);
    check("s5_pend3", int'(pendientes), 1);
    tick(5); check("s5_down", int'(direccion), 2);
    tick(24); check("s5_piso0", int'(piso), 0);
    check("s5_doors0", int'(puertas_abiertas), 1);
    check("s5_pend0", int'(pendientes), 0);

    // 6. reset mid-travel between floors 1 and 2
    do_reset();
    llamadas = 4'b1000;
    tick(1); llamadas = '0;
    tick(9); check("s6_piso1", int'(piso), 1);
    tick(3); rst_n = 1'b0;
    tick(1); rst_n = 1'b1;
    check("s6_piso", int'(piso), 0);
    check("s6_dir", int'(direccion), 0);
    check("s6_doors", int'(puertas_abiertas), 0);
    check("s6_pend", int'(pendientes), 0);

`ifdef ASC_MANTENER_PUERTA_EN
    do_reset();
    llamadas = 4'b0001;
    tick(1); llamadas = '0;
    tick(1); check("hold_open", int'(puertas_abiertas), 1);
    hold = 1'b1;
    tick(10); hold = 1'b0;
    tick(3); check("hold_still_open", int'(puertas_abiertas), 1);
    tick(1); check("hold_closed", int'(puertas_abiertas), 0);
`endif

    // random phase
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      rst_n = ($urandom_range(0, 799) != 0);
      llamadas = '0;
      if (r < 6) llamadas[$urandom_range(0, NP - 1)] = 1'b1;
      else if (r < 8) llamadas = NP'($urandom);
`ifdef ASC_MANTENER_PUERTA_EN
      hold = ($urandom_range(0, 39) == 0);
`endif
      tick(1);
    end
    llamadas = '0;
    hold = 1'b0;
    rst_n = 1'b1;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ascensor_ctrl.md
Name: ascensor_ctrl

Overview:
Parametrised single-car elevator controller, the successor to the fixed two-floor-bit test cars. It latches per-floor call requests and serves them with a collective (SCAN) policy: it finishes the current direction, then reverses. It drives the same floor, direction and door-state signals that the top-level LED and display logic consume. The top instantiates one copy per car.

Parameters:
N_PISOS, 4, number of floors, >=2; floor 0 is the lowest.
T_VIAJE, 50_000_000, clock cycles to travel one floor, >=1.
T_PUERTA, 100_000_000, clock cycles the doors stay open, >=1.
PISO_W, derived as max(1, $clog2(N_PISOS)), floor index width; not overridable.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
llamadas  in  N_PISOS  call request per floor; a one-cycle pulse or a level is accepted.
piso  out  PISO_W  current floor.
direccion  out  2  motion: 00 stopped, 01 up, 10 down; 11 is never driven.
puertas_abiertas  out  1  1 while doors are open.
pendientes  out  N_PISOS  latched outstanding calls.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all outputs and state clear:
  - piso=0, direccion=00, puertas_abiertas=0, pendientes=0.
  - state=REPOSO, timer=0, ultima_dir=up.
  - Reset mid-travel or mid-door drops everything, including pending calls.
- Latching: pendientes <= pendientes | llamadas every cycle.
  - The bit for piso clears on the cycle the controller enters PUERTAS.
  - A call for piso that arrives while in PUERTAS is absorbed: the bit is not set, and the door timer reloads to T_PUERTA.
- States: REPOSO, MOVIENDO, PUERTAS. direccion is 00 in REPOSO and PUERTAS.
- Decision function, used in REPOSO and on arrival at each floor:
  - Call at piso: go to PUERTAS.
  - Calls only above: go to MOVIENDO, up.
  - Calls only below: go to MOVIENDO, down.
  - Calls both above and below: continue in ultima_dir.
  - No calls: stay in REPOSO.
- REPOSO: evaluate the decision function every cycle. The result takes effect on the next edge, so latency is 1 cycle from a latched call to direccion or puertas_abiertas.
- MOVIENDO:
  - Load the timer with T_VIAJE-1 on entry and count down.
  - At 0: piso +/-1, ultima_dir <= current direction, then apply the decision function in the same cycle. If the result is to continue moving, the timer reloads.
  - piso never leaves 0..N_PISOS-1, because movement only occurs toward a pending bit. Verification asserts this.
- PUERTAS:
  - puertas_abiertas=1 for exactly T_PUERTA cycles, then go to REPOSO with doors closed.
  - Re-evaluation happens in the following cycle.
- A timer of width $clog2(max(T_VIAJE, T_PUERTA)+1) is shared between MOVIENDO and PUERTAS.
- llamadas bits at index >= N_PISOS do not exist. All pendientes arithmetic is N_PISOS wide.

Optional Feature:
ASC_MANTENER_PUERTA_EN:
- Defined: adds input port mantener_puerta (1 bit). While it is high in PUERTAS, the timer holds at T_PUERTA-1. The doors close T_PUERTA cycles after it falls.
- Undefined: the port is absent and door time is fixed.

Decomposition:
- Package ascensor_pkg holds:
  - Direction constants DIR_PARADO=2'b00, DIR_SUBE=2'b01, DIR_BAJA=2'b10.
  - The state encoding (REPOSO, MOVIENDO, PUERTAS).
  - Shared with controlador_display and the LED logic.
- Sub-module ascensor_temporizador: loadable down-counter, with inputs cargar and valor and output cero, parametrised on width. It is instantiated once.
- The above/below masks on pendientes stay combinational inside ascensor_ctrl.

Test Plan:
All scenarios use N_PISOS=4, T_VIAJE=8, T_PUERTA=4.
1. Reset: hold rst_n=0 for 3 cycles with llamadas=4'b1111 -> piso=0, direccion=00, puertas_abiertas=0, pendientes=0.
2. At piso 0, REPOSO, pulse llamadas=4'b1000 -> direccion=01 one cycle later. piso goes 1, 2, 3 at 8-cycle intervals. Doors open at 3 for 4 cycles, and pendientes=0 on door entry.
3. At piso 0, REPOSO, pulse llamadas[0] -> puertas_abiertas=1 next cycle for 4 cycles, direccion stays 00. A repeat pulse at door cycle 2 extends the opening to 2+4 cycles total.
4. Heading to floor 3 from 0, pulse llamadas[1] 3 cycles after departure -> stops at 1 (4 door cycles), then continues up to 3.
5. At piso 2 after travelling up, with doors closed, pulse llamadas=4'b1001 simultaneously -> serves 3 first, then travels down to 0.
6. Reset asserted mid-MOVIENDO between floors 1 and 2 -> outputs take reset values next edge, pendientes=0. With ASC_MANTENER_PUERTA_EN defined, mantener_puerta held for 10 cycles gives doors open 10+4 cycles.
